// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide engine.
package muldiv_pkg;

  localparam int unsigned MULDIV_W = 32;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix,
    StDone
  } muldiv_state_e;

  // Quotient returned for a zero divisor.
  localparam logic [MULDIV_W-1:0] DIV_ZERO_QUOT = '1;

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negation used for operand magnitudes and sign fix-up.
module muldiv_negate
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MULDIV_W
) (
  input  logic             en,
  input  logic [WIDTH-1:0] val,
  output logic [WIDTH-1:0] res
);

  assign res = en ? (~val + WIDTH'(1)) : val;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply (shift-add) and restoring divide on operand magnitudes,
// with a final sign-correction cycle. Produces HI/LO for the external register pair.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MULDIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic             sign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = $clog2(WIDTH);

  muldiv_state_e    state_q, state_d;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] acc_q;    // product upper half / partial remainder
  logic [WIDTH-1:0] low_q;    // multiplier shifting out / quotient shifting in
  logic [WIDTH-1:0] opnd_q;   // multiplicand / divisor magnitude
  logic             is_div_q, neg_q, neg_r_q, div_zero_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  logic [WIDTH-1:0]   a_mag, b_mag, quot_fix, rem_fix;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH:0]     mul_sum, div_shift;
  logic               div_ok;

  muldiv_negate #(.WIDTH(WIDTH)) u_neg_a (
    .en (sign & a[WIDTH-1]),
    .val(a),
    .res(a_mag)
  );

  muldiv_negate #(.WIDTH(WIDTH)) u_neg_b (
    .en (sign & b[WIDTH-1]),
    .val(b),
    .res(b_mag)
  );

  muldiv_negate #(.WIDTH(2 * WIDTH)) u_neg_prod (
    .en (neg_q),
    .val({acc_q, low_q}),
    .res(prod_fix)
  );

  muldiv_negate #(.WIDTH(WIDTH)) u_neg_quot (
    .en (neg_q),
    .val(low_q),
    .res(quot_fix)
  );

  muldiv_negate #(.WIDTH(WIDTH)) u_neg_rem (
    .en (neg_r_q),
    .val(acc_q),
    .res(rem_fix)
  );

  // One iteration of each algorithm; the carry/borrow lives in the extra top bit.
  assign mul_sum   = {1'b0, acc_q} + (low_q[0] ? {1'b0, opnd_q} : '0);
  assign div_shift = {acc_q, low_q[WIDTH-1]};
  assign div_ok    = div_shift >= {1'b0, opnd_q};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StCalc;
      StCalc:  if (cnt_q == CntW'(WIDTH - 1)) state_d = StFix;
      StFix:   state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);
  assign hi   = hi_q;
  assign lo   = lo_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      acc_q      <= '0;
      low_q      <= '0;
      opnd_q     <= '0;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      neg_r_q    <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        StIdle: begin
          if (start) begin
            is_div_q   <= is_div;
            neg_q      <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r_q    <= sign & a[WIDTH-1];
            div_zero_q <= (b == '0);
            cnt_q      <= '0;
            acc_q      <= '0;
            low_q      <= a_mag;
            opnd_q     <= b_mag;
          end
        end
        StCalc: begin
          cnt_q <= cnt_q + CntW'(1);
          if (is_div_q) begin
            acc_q <= div_ok ? WIDTH'(div_shift - {1'b0, opnd_q}) : div_shift[WIDTH-1:0];
            low_q <= {low_q[WIDTH-2:0], div_ok};
          end else begin
            acc_q <= mul_sum[WIDTH:1];
            low_q <= {mul_sum[0], low_q[WIDTH-1:1]};
          end
        end
        StFix: begin
          if (is_div_q) begin
            hi_q <= rem_fix;
            // The remainder path already yields the dividend; only the quotient needs forcing.
            lo_q <= div_zero_q ? {WIDTH{DIV_ZERO_QUOT[0]}} : quot_fix;
          end else begin
            {hi_q, lo_q} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed table, timing/abort sequence, random vs model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_div = 1'b0;
  logic        sign = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_fail = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .is_div(is_div),
    .sign  (sign),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not reach the summary");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic, truncating division, defined divide-by-zero.
  function automatic void model(input bit d, input bit s, input logic [31:0] x,
                                input logic [31:0] y, output logic [31:0] mh,
                                output logic [31:0] ml);
    longint sx, sy, r;
    sx = s ? longint'($signed(x)) : longint'({32'b0, x});
    sy = s ? longint'($signed(y)) : longint'({32'b0, y});
    if (!d) begin
      r  = sx * sy;
      mh = r[63:32];
      ml = r[31:0];
    end else if (y == 32'd0) begin
      mh = x;
      ml = 32'hFFFF_FFFF;
    end else begin
      ml = 32'(sx / sy);
      mh = 32'(sx % sy);
    end
  endfunction

  // Start in cycle 0; returns the cycle in which done was seen (bounded).
  task automatic run_op(input bit d, input bit s, input logic [31:0] ia, input logic [31:0] ib,
                        output logic [31:0] ohi, output logic [31:0] olo, output int lat,
                        output int busy_gaps);
    @(negedge clk);
    start = 1'b1; is_div = d; sign = s; a = ia; b = ib;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
    lat = 1;
    busy_gaps = 0;
    while (!done && lat < 100) begin
      if (!busy) busy_gaps++;
      @(negedge clk);
      lat++;
    end
    if (!busy) busy_gaps++;
    ohi = hi;
    olo = lo;
  endtask

  typedef struct {
    bit          d;
    bit          s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [31:0] rh, rl, eh, el;
    int lat, gaps, got_at, n_done;

    vecs[0] = '{0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1] = '{0, 1, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[2] = '{1, 1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{1, 0, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF};
    vecs[4] = '{1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5] = '{1, 0, 32'h0000_000A, 32'h0000_0003, 32'h0000_0001, 32'h0000_0003};
    vecs[6] = '{1, 1, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[7] = '{1, 1, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vecs[8] = '{0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset.busy", busy, 0);
    check("reset.done", done, 0);
    check("reset.hi", hi, 0);
    check("reset.lo", lo, 0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].d, vecs[i].s, vecs[i].a, vecs[i].b, rh, rl, lat, gaps);
      check($sformatf("vec%0d.hi", i), rh, vecs[i].hi);
      check($sformatf("vec%0d.lo", i), rl, vecs[i].lo);
      check($sformatf("vec%0d.latency", i), lat, 34);
      check($sformatf("vec%0d.busy_gaps", i), gaps, 0);
    end

    // Starts while busy are ignored; single done at cycle 34.
    @(negedge clk);
    start = 1'b1; is_div = 1'b1; sign = 1'b0; a = 32'd10; b = 32'd3;
    got_at = -1;
    n_done = 0;
    for (int c = 1; c <= 34; c++) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        if (got_at < 0) got_at = c;
      end
      start = (c == 5 || c == 20);
      if (start) begin
        is_div = 1'b0; sign = 1'b1; a = 32'h99; b = 32'h7;
      end
    end
    check("ignore.done_cycle", got_at, 34);
    check("ignore.done_count", n_done, 1);
    check("ignore.hi", hi, 32'd1);
    check("ignore.lo", lo, 32'd3);

    // Cycle 35: idle again, new start accepted.
    @(negedge clk);
    check("c35.busy", busy, 0);
    check("c35.done", done, 0);
    start = 1'b1; is_div = 1'b0; sign = 1'b0; a = 32'd6; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    check("c36.accepted", busy, 1);
    repeat (9) @(negedge clk);
    // Cycle 45: results still hold, then asynchronous abort.
    check("hold.hi", hi, 32'd1);
    check("hold.lo", lo, 32'd3);
    rst_n = 1'b0;
    #1;
    check("abort.busy", busy, 0);
    check("abort.done", done, 0);
    check("abort.hi", hi, 0);
    check("abort.lo", lo, 0);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("abort.no_done", n_done, 0);
    check("abort.idle", busy, 0);

    // Randomised operations against the reference model.
    for (int i = 0; i < 250; i++) begin
      bit d, s;
      logic [31:0] ra, rb;
      d  = 1'($urandom);
      s  = 1'($urandom);
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = $urandom_range(1, 15);
        2: ra = 32'h8000_0000;
        3: rb = 32'hFFFF_FFFF;
        4: ra = $urandom_range(0, 255);
        default: ;
      endcase
      model(d, s, ra, rb, eh, el);
      run_op(d, s, ra, rb, rh, rl, lat, gaps);
      check($sformatf("rand%0d(d=%0d s=%0d a=%h b=%h).hi", i, d, s, ra, rb), rh, eh);
      check($sformatf("rand%0d(d=%0d s=%0d a=%h b=%h).lo", i, d, s, ra, rb), rl, el);
      check($sformatf("rand%0d.latency", i), lat, 34);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
